// File: rtl/dmem_responder.sv
// Data-memory responder: posted store buffer with read-modify-write drain and
// byte-granular store-to-load forwarding in front of a single-ported word RAM.
module dmem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MemWriteM,
    input  logic                        MemReadM,
    input  logic [31:0]                 ALUResultM,
    input  logic [31:0]                 WriteDataM,
    input  logic [3:0]                  byteEnable,
    output logic [31:0]                 RD_data,
    output logic                        StallMem,
    output logic [$clog2(WBUF_DEPTH):0] WbufCount
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned PtrW = $clog2(WBUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StMerge} drainStateT;

    drainStateT stateQ, stateD;

    logic [PtrW-1:0] headQ, tailQ;
    logic [CntW-1:0] countQ, countD;
    logic [31:0]     mergeQ;

    logic [IdxW-1:0] bufIdx  [WBUF_DEPTH];
    logic [31:0]     bufData [WBUF_DEPTH];
    logic [3:0]      bufMask [WBUF_DEPTH];

    logic [31:0]     mem [MEM_WORDS];

    logic [IdxW-1:0] reqIdx;
    logic [31:0]     steered;
    logic            enq;
    logic            pop;
    logic            portFree;
    logic            ramWe;
    logic [31:0]     ramWdata;
    logic            mergeLoad;
    logic [IdxW-1:0] headIdx;
    logic [31:0]     headData;
    logic [3:0]      headMask;
    logic [PtrW-1:0] fwdSlot;
    logic            unusedAddr;

    // Upper address bits alias; the low two are already encoded in byteEnable.
    assign reqIdx     = ALUResultM[IdxW+1:2];
    assign unusedAddr = ^{ALUResultM[31:IdxW+2], ALUResultM[1:0]};

    assign headIdx  = bufIdx[headQ];
    assign headData = bufData[headQ];
    assign headMask = bufMask[headQ];

    assign portFree  = !MemReadM;
    assign StallMem  = MemWriteM && (byteEnable != 4'b0000) && (countQ == CntW'(WBUF_DEPTH));
    assign enq       = MemWriteM && (byteEnable != 4'b0000) && !StallMem;
    assign WbufCount = countQ;

    // Replicate the store data so every enabled lane already holds its byte.
    always_comb begin
        steered = WriteDataM;
        case (byteEnable)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: steered = {4{WriteDataM[7:0]}};
            4'b0011, 4'b1100:                   steered = {2{WriteDataM[15:0]}};
            default:                            steered = WriteDataM;
        endcase
    end

    // Drain FSM: full-word entries write directly, partial ones capture then merge.
    always_comb begin
        stateD    = stateQ;
        pop       = 1'b0;
        ramWe     = 1'b0;
        ramWdata  = headData;
        mergeLoad = 1'b0;
        case (stateQ)
            StIdle: begin
                if ((countQ != '0) && portFree) begin
                    if (headMask == 4'b1111) begin
                        ramWe = 1'b1;
                        pop   = 1'b1;
                    end else begin
                        mergeLoad = 1'b1;
                        stateD    = StMerge;
                    end
                end
            end
            StMerge: begin
                if (portFree) begin
                    for (int b = 0; b < 4; b++) begin
                        ramWdata[8*b +: 8] = headMask[b] ? headData[8*b +: 8] : mergeQ[8*b +: 8];
                    end
                    ramWe  = 1'b1;
                    pop    = 1'b1;
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Occupancy: simultaneous enqueue and pop leave the count unchanged.
    always_comb begin
        countD = countQ;
        if (enq && !pop) begin
            countD = countQ + CntW'(1);
        end else if (!enq && pop) begin
            countD = countQ - CntW'(1);
        end
    end

    // Control state; reset discards any pending stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            mergeQ <= '0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            if (enq) begin
                tailQ <= tailQ + PtrW'(1);
            end
            if (pop) begin
                headQ <= headQ + PtrW'(1);
            end
            if (mergeLoad) begin
                mergeQ <= mem[headIdx];
            end
        end
    end

    // Buffer payload; validity is tracked by head/count so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            bufIdx[tailQ]  <= reqIdx;
            bufData[tailQ] <= steered;
            bufMask[tailQ] <= byteEnable;
        end
    end

    // Single RAM write port, owned by the drain; suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!reset && ramWe) begin
            mem[headIdx] <= ramWdata;
        end
    end

    // Load path: RAM word overlaid by valid matching entries, oldest first.
    always_comb begin
        RD_data = mem[reqIdx];
        fwdSlot = '0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            fwdSlot = headQ + PtrW'(i);
            if ((CntW'(i) < countQ) && (bufIdx[fwdSlot] == reqIdx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (bufMask[fwdSlot][b]) begin
                        RD_data[8*b +: 8] = bufData[fwdSlot][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a queue-based reference model predicts
// RD_data, StallMem and WbufCount per cycle; a negedge monitor compares.
module tb_dmem_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  byteEnable;
    logic [31:0] RD_data;
    logic        StallMem;
    logic [2:0]  WbufCount;

    dmem_responder #(
        .MEM_WORDS  (1024),
        .WBUF_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .byteEnable (byteEnable),
        .RD_data    (RD_data),
        .StallMem   (StallMem),
        .WbufCount  (WbufCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    typedef struct {
        logic        isLoad;
        logic [31:0] rd;
        logic        stall;
        logic [2:0]  cnt;
        bit          hasConst;
        logic [31:0] constRd;
    } exp_t;

    entry_t      mq[$];
    exp_t        sbq[$];
    logic [31:0] mram [1024];
    bit          mMerging = 1'b0;
    logic [31:0] mMergeWord = '0;
    int          total = 0;
    int          bad = 0;
    exp_t        cur;

    // Per-lane store bytes from the architectural meaning of sb/sh/sw.
    function automatic logic [31:0] laneData(logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        int n;
        r = '0;
        n = $countones(be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                if (n == 1)      r[8*b +: 8] = wd[7:0];
                else if (n == 2) r[8*b +: 8] = wd[8*(b%2) +: 8];
                else             r[8*b +: 8] = wd[8*b +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] overlay(logic [31:0] base, entry_t e);
        logic [31:0] w;
        w = base;
        for (int b = 0; b < 4; b++) begin
            if (e.mask[b]) w[8*b +: 8] = e.data[8*b +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] modelRead(int unsigned idx);
        logic [31:0] w;
        w = mram[idx];
        foreach (mq[k]) begin
            if (mq[k].idx == idx) w = overlay(w, mq[k]);
        end
        return w;
    endfunction

    // One clock of stimulus: drive, predict outputs, advance the model.
    task automatic step(input logic wr, input logic rdReq, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic rst,
                        input bit hasConst, input logic [31:0] constRd, output bit stalled);
        exp_t        e;
        entry_t      ne;
        int unsigned idx;
        bit          st;
        idx        = int'(addr[11:2]);
        reset      = rst;
        MemWriteM  = wr;
        MemReadM   = rdReq;
        ALUResultM = addr;
        WriteDataM = wd;
        byteEnable = be;
        st = wr && (be != 4'b0000) && (mq.size() == DEPTH);
        e.isLoad   = rdReq;
        e.rd       = modelRead(idx);
        e.stall    = st;
        e.cnt      = 3'(mq.size());
        e.hasConst = hasConst;
        e.constRd  = constRd;
        sbq.push_back(e);
        if (rst) begin
            mq.delete();
            mMerging = 1'b0;
        end else begin
            if (!rdReq && mq.size() > 0) begin
                if (mMerging) begin
                    mram[mq[0].idx] = overlay(mMergeWord, mq[0]);
                    mq.delete(0);
                    mMerging = 1'b0;
                end else if (mq[0].mask == 4'hF) begin
                    mram[mq[0].idx] = mq[0].data;
                    mq.delete(0);
                end else begin
                    mMergeWord = mram[mq[0].idx];
                    mMerging   = 1'b1;
                end
            end
            if (wr && be != 4'b0000 && !st) begin
                ne.idx  = idx;
                ne.data = laneData(wd, be);
                ne.mask = be;
                mq.push_back(ne);
            end
        end
        stalled = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit s;
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, s);
    endtask

    task automatic load(input logic [31:0] a, input bit hc, input logic [31:0] c);
        bit s;
        step(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, hc, c, s);
    endtask

    // Store held and retried while stalled, as the hazard unit would do.
    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic withLd);
        bit s;
        int tries;
        tries = 0;
        do begin
            step(1'b1, withLd, a, wd, be, 1'b0, 1'b0, 32'h0, s);
            tries++;
        end while (s && tries < 16);
        if (s) begin
            total++;
            bad++;
            $display("FAIL store_retry: addr %h still stalled after %0d tries, required accept",
                     a, tries);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (mq.size() > 0 && n < 40) begin
            idle(1);
            n++;
        end
        if (mq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL settle: %0d entries left after %0d cycles, required 0", mq.size(), n);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        store(a, v, 4'hF, 1'b0);
        settle();
    endtask

    // Monitor: one expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            total++;
            if (StallMem !== cur.stall) begin
                bad++;
                $display("FAIL stall_mem: got %b want %b at %0t", StallMem, cur.stall, $time);
            end
            total++;
            if (WbufCount !== cur.cnt) begin
                bad++;
                $display("FAIL wbuf_count: got %0d want %0d at %0t", WbufCount, cur.cnt, $time);
            end
            if (cur.isLoad) begin
                total++;
                if (RD_data !== cur.rd) begin
                    bad++;
                    $display("FAIL rd_model: got %h want %h at %0t", RD_data, cur.rd, $time);
                end
            end
            if (cur.hasConst) begin
                total++;
                if (RD_data !== cur.constRd) begin
                    bad++;
                    $display("FAIL rd_direct: got %h want %h at %0t", RD_data, cur.constRd, $time);
                end
            end
        end
    end

    logic [3:0] beTab [8];

    initial begin
        bit          s;
        int          r;
        int          w;
        logic [31:0] rnd;
        logic [9:0]  idxv;
        logic [31:0] a;

        beTab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000};
        foreach (mram[k]) mram[k] = '0;

        reset      = 1'b1;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        byteEnable = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: a full store request must not stall with an empty buffer.
        step(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, s);
        // Forwarding from the buffer, then drain into RAM.
        load(32'h100, 1'b1, 32'hDEADBEEF);
        idle(1);
        load(32'h100, 1'b1, 32'hDEADBEEF);

        // Byte read-modify-write.
        preload(32'h40, 32'h11223344);
        store(32'h41, 32'h000000AB, 4'b0010, 1'b0);
        idle(2);
        load(32'h40, 1'b1, 32'h1122AB44);

        // Youngest store wins per byte while loads block the drain.
        preload(32'h200, 32'h0);
        store(32'h202, 32'h0000BEEF, 4'b1100, 1'b1);
        store(32'h203, 32'h00000077, 4'b1000, 1'b1);
        load(32'h200, 1'b1, 32'h77EF0000);
        settle();
        load(32'h200, 1'b1, 32'h77EF0000);

        // Full buffer: eight back-to-back byte stores.
        preload(32'h300, 32'h0);
        preload(32'h304, 32'h0);
        for (int i = 0; i < 8; i++) store(32'h300 + i, 32'h10 + i, 4'b0001 << (i % 4), 1'b0);
        settle();
        load(32'h300, 1'b1, 32'h13121110);
        load(32'h304, 1'b1, 32'h17161514);

        // Loads hold the merge step.
        preload(32'h400, 32'hA5A5A5A5);
        store(32'h401, 32'h0000003C, 4'b0010, 1'b0);
        idle(1);
        repeat (5) load(32'h400, 1'b1, 32'hA5A53CA5);
        idle(1);
        load(32'h400, 1'b1, 32'hA5A53CA5);

        // Reset in the middle of a merge discards buffered stores.
        preload(32'h500, 32'h01010101);
        preload(32'h504, 32'h02020202);
        preload(32'h508, 32'h03030303);
        store(32'h501, 32'h000000EE, 4'b0010, 1'b1);
        store(32'h506, 32'h000000DD, 4'b0100, 1'b1);
        store(32'h50B, 32'h000000CC, 4'b1000, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, s);
        step(1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, s);
        settle();
        load(32'h500, 1'b1, 32'h01010101);
        load(32'h504, 1'b1, 32'h02020202);
        load(32'h508, 1'b1, 32'h03030303);

        // Randomized traffic over eight aliased words.
        for (int k = 0; k < 8; k++) preload(32'hC0 + 4 * k, $urandom());
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 99);
            rnd  = $urandom();
            idxv = 10'h30 + 10'($urandom_range(0, 7));
            a    = {rnd[31:12], idxv, rnd[1:0]};
            if (r < 35) begin
                load(a, 1'b0, 32'h0);
            end else if (r < 75) begin
                step(1'b1, 1'b0, a, $urandom(), beTab[$urandom_range(0, 7)], 1'b0, 1'b0,
                     32'h0, s);
            end else if (r < 80) begin
                step(1'b1, 1'b1, a, $urandom(), beTab[$urandom_range(0, 7)], 1'b0, 1'b0,
                     32'h0, s);
            end else begin
                idle(1);
            end
        end
        settle();
        for (int k = 0; k < 8; k++) load(32'hC0 + 4 * k, 1'b0, 32'h0);

        w = 0;
        while (sbq.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        #1;
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations unchecked, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
